// File: rtl/treg_writer.sv
// -----------------------------------------------------------------------------
// treg_writer
//   Write-side controller for a toggle-flip-flop register. A target value is
//   accepted through a VALID/READY handshake. The block then issues one-hot
//   toggle masks, one bit per cycle and LSB first, until the register matches
//   the target. Stepping a single bit per cycle limits how many register
//   outputs switch at once.
//
//   A mirror of the downstream toggle register is kept internally. That
//   register shares CLK/RESET with this block, so Q always equals its contents.
//
// Ports
//   CLK     in   system clock, rising edge
//   RESET   in   synchronous, active-high reset
//   VALID   in   TARGET is presented this cycle
//   TARGET  in   [WIDTH] value the register must reach
//   ABORT   in   stop an in-progress write (masks TOGGLE in that cycle)
//   READY   out  a new target is accepted this cycle
//   TOGGLE  out  [WIDTH] T-input mask, at most one bit set
//   Q       out  [WIDTH] current register value (mirror)
//   BUSY    out  write in progress
//   DONE    out  one-cycle pulse when a write completes normally
//   STEPS   out  [CW] toggles issued for the current or most recent write
// -----------------------------------------------------------------------------

// Per-bit slice: one mirror bit and one target bit.
module treg_writer_lane (
  input  logic CLK,
  input  logic RESET,
  input  logic ld_i,    // latch a new target bit
  input  logic tgt_i,
  input  logic tog_i,   // toggle applied at this edge
  output logic q_o,
  output logic diff_o   // target and mirror disagree
);
  logic q_q, q_d;
  logic tgt_q, tgt_d;

  assign q_d   = q_q ^ tog_i;
  assign tgt_d = ld_i ? tgt_i : tgt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q   <= 1'b0;
      tgt_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tgt_q <= tgt_d;
    end
  end

  assign q_o    = q_q;
  assign diff_o = q_q ^ tgt_q;
endmodule

module treg_writer #(
  parameter int WIDTH = 4,
  parameter int CW    = 3   // 2**CW must exceed WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VALID,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             ABORT,
  output logic             READY,
  output logic [WIDTH-1:0] TOGGLE,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [CW-1:0]    STEPS
);
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    steps_q, steps_d;
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] lowbit;
  logic             last_bit;
  logic             accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    treg_writer_lane u_lane (
      .CLK    (CLK),
      .RESET  (RESET),
      .ld_i   (accept),
      .tgt_i  (TARGET[i]),
      .tog_i  (TOGGLE[i]),
      .q_o    (q_vec[i]),
      .diff_o (diff[i])
    );
  end

  // Two's-complement trick isolates the lowest set bit. Clearing that bit
  // leaves zero exactly when a single bit remains, which means this toggle
  // is the last one of the write.
  assign lowbit   = diff & (~diff + WIDTH'(1));
  assign last_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    accept  = 1'b0;
    READY   = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    TOGGLE  = '0;
    case (state_q)
      S_IDLE: begin
        READY = 1'b1;
        if (VALID) begin
          accept  = 1'b1;
          steps_d = '0;
          // When the target already matches, the write completes in zero steps.
          state_d = (TARGET == q_vec) ? S_FIN : S_STEP;
        end
      end
      S_STEP: begin
        BUSY = 1'b1;
        if (ABORT) begin
          // Leave Q partially written and keep STEPS frozen. No DONE is raised.
          state_d = S_IDLE;
        end else begin
          TOGGLE  = lowbit;
          steps_d = steps_q + CW'(1);
          if (last_bit) state_d = S_FIN;
        end
      end
      S_FIN: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
    end
  end

  assign Q     = q_vec;
  assign STEPS = steps_q;
endmodule

// File: doc/treg_writer.md
Name: treg_writer

Overview:
- Write-side controller for a toggle-flip-flop register: takes a target value through a valid/ready handshake and issues one-hot toggle masks, one bit per cycle, LSB first, until the register equals the target.
- Keeps an internal mirror of the toggle register. TOGGLE drives the T inputs of a downstream toggle register that is reset on the same CLK/RESET; Q always equals that register's contents.
- Single-bit-per-cycle stepping limits simultaneous switching on the register outputs.

Parameters:
- WIDTH, 4, width of target, mirror and toggle mask.
- CW, 3, width of STEPS counter; must satisfy 2^CW > WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- VALID  input  1  TARGET is presented this cycle.
- TARGET  input  WIDTH  value the register must reach.
- ABORT  input  1  stop an in-progress write.
- READY  output  1  block accepts a new target this cycle.
- TOGGLE  output  WIDTH  toggle mask for the downstream T inputs; at most one bit set.
- Q  output  WIDTH  current register value (mirror).
- BUSY  output  1  write in progress.
- DONE  output  1  one-cycle pulse: write completed normally.
- STEPS  output  CW  toggles issued for the current or most recent write.

Behaviour:
- One clock. Reset is synchronous and active-high. CLK and RESET are named as in the codebase.
- Reset (RESET high at a rising edge): state IDLE, Q=0, TGT=0, STEPS=0, DONE=0. This gives READY=1, BUSY=0, TOGGLE=0. RESET overrides all other inputs and aborts any write in progress.
- DIFF = TGT ^ Q (combinational). LOWBIT = isolated lowest set bit of DIFF.
- States: IDLE, STEP, FIN.
- IDLE:
  - READY=1, BUSY=0, TOGGLE=0.
  - On VALID: TGT<=TARGET and STEPS<=0.
  - If TARGET==Q, go to FIN (zero-step write). Otherwise go to STEP.
  - ABORT is ignored in IDLE.
- STEP:
  - READY=0, BUSY=1, TOGGLE=LOWBIT.
  - At the edge: Q<=Q^TOGGLE and STEPS<=STEPS+1.
  - If DIFF has exactly one set bit, go to FIN; otherwise stay in STEP.
  - VALID is ignored (not accepted, no TGT change).
- FIN:
  - READY=0, BUSY=0, TOGGLE=0, DONE=1 for this single cycle.
  - Always returns to IDLE.
- ABORT in STEP:
  - TOGGLE is forced to 0 in that cycle; Q and STEPS hold.
  - Next state is IDLE, with no DONE pulse.
  - Q keeps its partially written value.
- Latency from acceptance edge to DONE:
  - popcount(TARGET ^ Q_at_accept) STEP cycles, then 1 FIN cycle.
  - READY returns the cycle after FIN.
  - A zero-step write gives DONE one cycle after acceptance.
- Invariants:
  - TOGGLE has popcount ≤1 at all times.
  - TOGGLE is 0 outside STEP.
  - Q changes only by the TOGGLE bit applied at that edge.
- STEPS holds its final value after a write completes or aborts, until the next acceptance clears it. It never exceeds WIDTH.
- Back-to-back writes:
  - A new VALID is accepted in the first IDLE cycle after FIN.
  - Minimum spacing between acceptances is popcount+2 cycles.
- All outputs are either registered or decoded from the state and registered values only. There is no combinational path from VALID, TARGET or ABORT to TOGGLE, except ABORT masking TOGGLE in STEP.

Test Plan:
- Reset, then VALID with TARGET=4'b1011 → TOGGLE sequence 0001, 0010, 1000 on consecutive cycles. Q goes 0000→0001→0011→1011. DONE pulses 1 cycle after the last toggle. STEPS=3. READY high the next cycle.
- From Q=1011, VALID with TARGET=1011 → no toggles, DONE one cycle after acceptance, STEPS=0.
- From Q=0000, TARGET=1111, ABORT asserted in the 3rd STEP cycle → TOGGLE=0 that cycle. Q=0011, no DONE, READY=1 the next cycle, STEPS=2.
- VALID with TARGET=0000 asserted continuously during a write to 0110 → that TARGET is ignored while BUSY. It is accepted only at the first IDLE cycle, after which Q walks 0110→0100→0000.
- RESET asserted mid-write (Q=0001, target 1001) → next cycle Q=0, TOGGLE=0, READY=1, STEPS=0, no DONE.
- Throughout all scenarios, a scoreboard T-register model driven by TOGGLE matches Q every cycle, and TOGGLE is checked to be one-hot or zero.
